// File: rtl/fhe_mem_pkg.sv
// Shared types and defaults for the memory port arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fhe_mem_pkg;

    localparam int DEF_AW      = 64;
    localparam int DEF_DW      = 64;
    localparam int DEF_MAX_OUT = 4;
    localparam int MAX_NREQ    = 4;

    // Requester index; wide enough for the largest supported requester count.
    typedef logic [$clog2(MAX_NREQ)-1:0] req_id_t;

endpackage

// File: rtl/mem_id_fifo.sv
// In-order FIFO of requester IDs for outstanding reads.
// Latency: head valid combinationally; push visible on the next clk edge.
// Backpressure: push ignored when full, pop ignored when empty; push+pop together keeps count.
// Ports: clk/rst (sync, active-high), push/push_id, pop, head, full, empty.
module mem_id_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra MSB on each pointer separates full from empty when the index bits match.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[PW-1:0]] <= push_id;
                wr_ptr              <= wr_ptr + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among NREQ masters, with burst lock and in-order read steering.
// Latency: request->m_req, m_gnt->gnt and m_rvalid->rvalid are all combinational (0 cycles).
// Backpressure: winner held while m_gnt is low; reads stall when MAX_OUT reads are outstanding.
// Ports: per-requester req/we/lock/addr/wdata in, gnt/rvalid out; rdata broadcast;
//        memory side m_req/m_we/m_addr/m_wdata out, m_gnt/m_rvalid/m_rdata in; sticky err_orphan.
module mem_port_arbiter
    import fhe_mem_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int MAX_OUT = DEF_MAX_OUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               m_req,
    output logic               m_we,
    output logic [AW-1:0]      m_addr,
    output logic [DW-1:0]      m_wdata,
    input  logic               m_gnt,
    input  logic               m_rvalid,
    input  logic [DW-1:0]      m_rdata,
    output logic               err_orphan
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    req_id_t         last_winner;
    req_id_t         owner;
    logic            owner_vld;
    req_id_t         winner;
    logic            sel_vld;
    logic            lock_held;
    logic            lock_sel;
    int              best_dist;
    logic [NREQ-1:0] elig;
    logic            fifo_full;
    logic            fifo_empty;
    logic [IDW-1:0]  fifo_head;
    logic            beat_acc;
    logic            push;
    logic            pop;

    // Writes never occupy a response slot, so only reads are held off by a full FIFO.
    assign elig = req & (we | {NREQ{~fifo_full}});

    always_comb begin
        sel_vld   = 1'b0;
        winner    = '0;
        lock_held = 1'b0;
        best_dist = NREQ;
        // A lock only masks others while its owner still requests; a dropped req frees the port at once.
        for (int i = 0; i < NREQ; i++) begin
            if (owner_vld && owner == req_id_t'(i) && req[i]) begin
                lock_held = 1'b1;
                if (elig[i]) begin
                    sel_vld = 1'b1;
                    winner  = req_id_t'(i);
                end
            end
        end
        if (!lock_held) begin
            // Distance 0 is the index just after last_winner; the closest eligible index wins.
            for (int i = 0; i < NREQ; i++) begin
                if (elig[i] && ((i - int'(last_winner) - 1 + 2*NREQ) % NREQ) < best_dist) begin
                    best_dist = (i - int'(last_winner) - 1 + 2*NREQ) % NREQ;
                    sel_vld   = 1'b1;
                    winner    = req_id_t'(i);
                end
            end
        end
    end

    always_comb begin
        m_req    = sel_vld;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        lock_sel = 1'b0;
        gnt      = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel_vld && winner == req_id_t'(i)) begin
                m_we     = we[i];
                m_addr   = addr[i*AW +: AW];
                m_wdata  = wdata[i*DW +: DW];
                lock_sel = lock[i];
                gnt[i]   = m_gnt;
            end
        end
    end

    assign beat_acc = sel_vld && m_gnt;
    assign push     = beat_acc && !m_we;
    assign pop      = m_rvalid && !fifo_empty;

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rvalid[i] = pop && (fifo_head == IDW'(i));
        end
    end

    assign rdata = pop ? m_rdata : '0;

    mem_id_fifo #(
        .DEPTH (MAX_OUT),
        .W     (IDW)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (IDW'(winner)),
        .pop     (pop),
        .head    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner <= req_id_t'(NREQ-1);
            owner       <= '0;
            owner_vld   <= 1'b0;
            err_orphan  <= 1'b0;
        end else begin
            if (beat_acc) begin
                last_winner <= winner;
                owner       <= winner;
                owner_vld   <= lock_sel;
            end else if (owner_vld && !lock_held) begin
                owner_vld <= 1'b0;
            end
            if (m_rvalid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    localparam int NREQ    = 2;
    localparam int AW      = 64;
    localparam int DW      = 64;
    localparam int MAX_OUT = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    we;
    logic [NREQ-1:0]    lock;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               m_req;
    logic               m_we;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_gnt;
    logic               m_rvalid;
    logic [DW-1:0]      m_rdata;
    logic               err_orphan;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_port_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .we         (we),
        .lock       (lock),
        .addr       (addr),
        .wdata      (wdata),
        .gnt        (gnt),
        .rvalid     (rvalid),
        .rdata      (rdata),
        .m_req      (m_req),
        .m_we       (m_we),
        .m_addr     (m_addr),
        .m_wdata    (m_wdata),
        .m_gnt      (m_gnt),
        .m_rvalid   (m_rvalid),
        .m_rdata    (m_rdata),
        .err_orphan (err_orphan)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req      = '0;
        we       = '0;
        lock     = '0;
        addr     = '0;
        wdata    = '0;
        m_gnt    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++;
        if (m_req !== 1'b0) $display("FAIL reset_m_req: got %b expected 0", m_req); else pass_cnt++;
        total_cnt++;
        if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt); else pass_cnt++;
        total_cnt++;
        if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", rvalid); else pass_cnt++;
        total_cnt++;
        if (m_addr !== 64'h0) $display("FAIL reset_m_addr: got %h expected 0", m_addr); else pass_cnt++;
        total_cnt++;
        if (err_orphan !== 1'b0) $display("FAIL reset_err_orphan: got %b expected 0", err_orphan); else pass_cnt++;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt;
        logic [63:0] exp_addr;
        do_reset();
        req   = 2'b11;
        we    = 2'b11;
        addr[0 +: 64]  = 64'h100;
        addr[64 +: 64] = 64'h200;
        wdata[0 +: 64]  = 64'hD0;
        wdata[64 +: 64] = 64'hD1;
        m_gnt = 1'b1;
        for (int c = 0; c < 6; c++) begin
            exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (c % 2 == 0) ? 64'h100 : 64'h200;
            #1;
            total_cnt++;
            if (gnt !== exp_gnt) $display("FAIL rr_gnt c%0d: got %b expected %b", c, gnt, exp_gnt); else pass_cnt++;
            total_cnt++;
            if (m_addr !== exp_addr) $display("FAIL rr_addr c%0d: got %h expected %h", c, m_addr, exp_addr); else pass_cnt++;
            tick();
        end
        idle();
    endtask

    task automatic test_burst_lock();
        logic [63:0] exp_addr;
        do_reset();
        req   = 2'b11;
        we    = 2'b11;
        addr[64 +: 64] = 64'h2000;
        m_gnt = 1'b1;
        for (int b = 0; b < 10; b++) begin
            exp_addr       = 64'h1000 + 64'(8 * b);
            addr[0 +: 64]  = exp_addr;
            lock           = (b < 9) ? 2'b01 : 2'b00;
            #1;
            total_cnt++;
            if (gnt !== 2'b01 || m_addr !== exp_addr)
                $display("FAIL burst_beat%0d: got gnt=%b addr=%h expected gnt=01 addr=%h", b, gnt, m_addr, exp_addr);
            else pass_cnt++;
            tick();
        end
        lock = 2'b00;
        #1;
        total_cnt++;
        if (gnt !== 2'b10 || m_addr !== 64'h2000)
            $display("FAIL burst_release: got gnt=%b addr=%h expected gnt=10 addr=2000", gnt, m_addr);
        else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        req   = 2'b11;
        we    = 2'b11;
        addr[0 +: 64]  = 64'h100;
        addr[64 +: 64] = 64'h200;
        m_gnt = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            total_cnt++;
            if (m_req !== 1'b1 || gnt !== 2'b00 || m_addr !== 64'h100)
                $display("FAIL bp_stall c%0d: got m_req=%b gnt=%b addr=%h expected 1/00/100", c, m_req, gnt, m_addr);
            else pass_cnt++;
            tick();
        end
        m_gnt = 1'b1;
        #1;
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL bp_resume: got %b expected 01", gnt); else pass_cnt++;
        tick();
        total_cnt++;
        if (gnt !== 2'b10) $display("FAIL bp_next: got %b expected 10", gnt); else pass_cnt++;
        tick();
        idle();
    endtask

    task automatic test_read_steering();
        logic [1:0]  exp_rv [3];
        logic [63:0] exp_d  [3];
        exp_rv[0] = 2'b10; exp_rv[1] = 2'b01; exp_rv[2] = 2'b10;
        exp_d[0]  = 64'hA; exp_d[1]  = 64'hB; exp_d[2]  = 64'hC;
        do_reset();
        we    = 2'b00;
        m_gnt = 1'b1;
        addr[0 +: 64]  = 64'h40;
        addr[64 +: 64] = 64'h80;
        for (int r = 0; r < 3; r++) begin
            req = exp_rv[r];
            #1;
            total_cnt++;
            if (gnt !== exp_rv[r] || m_we !== 1'b0)
                $display("FAIL rd_issue%0d: got gnt=%b we=%b expected gnt=%b we=0", r, gnt, m_we, exp_rv[r]);
            else pass_cnt++;
            tick();
        end
        req   = 2'b00;
        m_gnt = 1'b0;
        for (int r = 0; r < 3; r++) begin
            m_rvalid = 1'b1;
            m_rdata  = exp_d[r];
            #1;
            total_cnt++;
            if (rvalid !== exp_rv[r] || rdata !== exp_d[r])
                $display("FAIL rd_resp%0d: got rvalid=%b rdata=%h expected %b/%h", r, rvalid, rdata, exp_rv[r], exp_d[r]);
            else pass_cnt++;
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        total_cnt++;
        if (err_orphan !== 1'b0) $display("FAIL rd_no_orphan: got %b expected 0", err_orphan); else pass_cnt++;
        idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        req   = 2'b01;
        we    = 2'b00;
        m_gnt = 1'b1;
        addr[0 +: 64]  = 64'h300;
        addr[64 +: 64] = 64'h400;
        for (int r = 0; r < 4; r++) begin
            tick();
        end
        // Four reads outstanding: requester 0 read must be blocked, requester 1 write proceeds.
        req = 2'b11;
        we  = 2'b10;
        #1;
        total_cnt++;
        if (gnt !== 2'b10 || m_we !== 1'b1)
            $display("FAIL full_block: got gnt=%b we=%b expected 10/1", gnt, m_we);
        else pass_cnt++;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = 64'h55;
        #1;
        total_cnt++;
        if (gnt !== 2'b10) $display("FAIL full_still_block: got %b expected 10", gnt); else pass_cnt++;
        total_cnt++;
        if (rvalid !== 2'b01 || rdata !== 64'h55)
            $display("FAIL full_pop: got rvalid=%b rdata=%h expected 01/55", rvalid, rdata);
        else pass_cnt++;
        tick();
        m_rvalid = 1'b0;
        #1;
        total_cnt++;
        if (gnt !== 2'b01) $display("FAIL full_unblock: got %b expected 01", gnt); else pass_cnt++;
        tick();
        req   = 2'b00;
        m_gnt = 1'b0;
        for (int r = 0; r < 4; r++) begin
            m_rvalid = 1'b1;
            m_rdata  = 64'(r + 1);
            #1;
            total_cnt++;
            if (rvalid !== 2'b01) $display("FAIL full_drain%0d: got %b expected 01", r, rvalid); else pass_cnt++;
            tick();
        end
        m_rvalid = 1'b0;
        #1;
        total_cnt++;
        if (err_orphan !== 1'b0) $display("FAIL full_no_orphan: got %b expected 0", err_orphan); else pass_cnt++;
        idle();
    endtask

    task automatic test_orphan_reset();
        do_reset();
        m_rvalid = 1'b1;
        m_rdata  = 64'h77;
        #1;
        total_cnt++;
        if (rvalid !== 2'b00) $display("FAIL orphan_rvalid: got %b expected 00", rvalid); else pass_cnt++;
        tick();
        m_rvalid = 1'b0;
        #1;
        total_cnt++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_set: got %b expected 1", err_orphan); else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (err_orphan !== 1'b1) $display("FAIL orphan_sticky: got %b expected 1", err_orphan); else pass_cnt++;
        do_reset();
        #1;
        total_cnt++;
        if (err_orphan !== 1'b0) $display("FAIL orphan_clear: got %b expected 0", err_orphan); else pass_cnt++;
        req   = 2'b01;
        we    = 2'b00;
        m_gnt = 1'b1;
        addr[0 +: 64] = 64'h500;
        tick();
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_rvalid = 1'b1;
        m_rdata  = 64'h99;
        #1;
        total_cnt++;
        if (rvalid !== 2'b00) $display("FAIL late_rvalid: got %b expected 00", rvalid); else pass_cnt++;
        tick();
        m_rvalid = 1'b0;
        #1;
        total_cnt++;
        if (err_orphan !== 1'b1) $display("FAIL late_orphan: got %b expected 1", err_orphan); else pass_cnt++;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_backpressure();
        test_read_steering();
        test_fifo_full();
        test_orphan_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single 64-bit memory port between several masters: the DMA unit, the core load/store path and the NTT operand loader. Each cycle it picks one requester round-robin and forwards that request to the memory port. It also supports burst locking, so a multi-word DMA transfer is never interleaved. Read responses return in order and are steered back to the master that issued them, using a small FIFO of requester IDs.

## Interface
Parameters:
- NREQ, 2: number of requesters (2..4).
- AW, 64: address width.
- DW, 64: data width.
- MAX_OUT, 4: maximum outstanding reads (FIFO depth, power of 2).

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  NREQ  per-requester request.
- we  in  NREQ  per-requester write enable.
- lock  in  NREQ  hold ownership after the current beat.
- addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- wdata  in  NREQ*DW  flattened write data.
- gnt  out  NREQ  one-hot; beat accepted this cycle.
- rvalid  out  NREQ  one-hot; read data for requester i.
- rdata  out  DW  broadcast read data.
- m_req, m_we  out  1  memory port request and write enable.
- m_addr  out  AW  memory port address.
- m_wdata  out  DW  memory port write data.
- m_gnt  in  1  memory accepts the beat.
- m_rvalid  in  1  memory read data valid (in order).
- m_rdata  in  DW  memory read data.
- err_orphan  out  1  sticky: m_rvalid seen while no read was outstanding.

## Operation
- Eligibility: requester i is eligible when req[i] is high and either we[i]=1 or the ID FIFO is not full.
- Selection (combinational), in priority order:
  - Locked owner: if the owner is valid and eligible, it wins.
  - Otherwise the first eligible index searching upward from last_winner+1, modulo NREQ.
- Lock lifecycle:
  - A winner with lock=1 on an accepted beat becomes the locked owner.
  - Ownership is released on an accepted beat with lock=0, or when the owner drops req.
  - While a lock is held, all other requesters are masked.
- Forwarding:
  - m_req is high when any requester is selected.
  - m_we, m_addr and m_wdata are muxed from the winner.
  - gnt[winner] = m_gnt && m_req.
- Accepted beat (m_req && m_gnt): last_winner <= winner. If it is a read, the winner ID is pushed into the FIFO.
- m_rvalid:
  - FIFO not empty: pop the head, assert rvalid[head] = 1, and drive rdata = m_rdata.
  - FIFO empty: no rvalid is raised and err_orphan is set. It stays set until rst.
- Push and pop in the same cycle are both performed; the count is unchanged. A push with the FIFO full cannot occur because of the eligibility rule.
- ID width is clog2(NREQ). FIFO pointers are log2(MAX_OUT) bits, plus 1 extra bit for the full/empty distinction; they wrap naturally.

## Timing
- Request to m_req / m_addr: combinational, 0 cycles.
- m_gnt to gnt: combinational, 0 cycles.
- m_rvalid to rvalid / rdata: combinational, 0 cycles.
- State updates on the clk edge following an accepted beat or response.
- Reset values:
  - last_winner = NREQ-1, so requester 0 wins first.
  - Lock owner invalid.
  - FIFO empty, pointers 0.
  - err_orphan = 0.
  - All outputs 0 while no req is asserted.
- Requester rules:
  - A requester holds req, we, addr and wdata stable until gnt.
  - It may change them in the cycle after gnt.
  - Without m_gnt, the winner stays selected; the pointer does not advance.
- Reset mid-operation: outstanding read IDs are discarded. A late m_rvalid after reset sets err_orphan.

## Structure
- Package fhe_mem_pkg holds:
  - AW and DW defaults.
  - The MAX_OUT default.
  - A req_id_t typedef sized for NREQ ≤ 4.
- Sub-module: mem_id_fifo (parameter depth, ID width). It has push, pop, full, empty and head outputs, and supports simultaneous push/pop.
- The arbiter top holds:
  - The round-robin pointer.
  - The lock owner register.
  - The request/data muxing.

## Test plan
- Round-robin fairness:
  - Stimulus: NREQ=2, both issue continuous writes, m_gnt=1.
  - Response: gnt alternates 01,10,01,…, starting with requester 0 after reset.
- Burst lock:
  - Stimulus: requester 0 issues 10 writes to 0x1000 with lock=1 for beats 0–8 and lock=0 on beat 9; requester 1 requests throughout.
  - Response: m_addr steps 0x1000..0x1048 uninterrupted, and requester 1 is granted on the 11th beat.
- Backpressure:
  - Stimulus: m_gnt low for 5 cycles with both requesting.
  - Response: the selected winner and m_addr are unchanged, no gnt is raised, and the pointer does not move.
- Read steering:
  - Stimulus: requesters 1, 0, 1 issue reads; memory returns 0xA, 0xB, 0xC in order.
  - Response: rvalid is 10, 01, 10 respectively, with rdata matching.
- FIFO full:
  - Stimulus: MAX_OUT=4, 4 reads outstanding, requester 0 read plus requester 1 write pending.
  - Response: requester 1 is granted and requester 0 is blocked. With a simultaneous m_rvalid, requester 0 is eligible the next cycle.
- Orphan and reset:
  - Stimulus: m_rvalid with the FIFO empty, or rst asserted with 2 reads outstanding followed by a late m_rvalid.
  - Response: err_orphan=1 and no rvalid is raised; the FIFO is empty after rst.
